// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage defaults and the command decode used by the PC sequencer.
// The defaults are also consumed by the instruction-memory blocks.
package pc_sequencer_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT        = 32;
    localparam int unsigned PC_STEP_DEFAULT         = 1;
    localparam int unsigned PC_RESET_VECTOR_DEFAULT = 0;

    typedef enum logic [2:0] {
        CMD_STALL,
        CMD_RET,
        CMD_JUMP,
        CMD_CALL,
        CMD_SEQ
    } pc_cmd_e;

    // Priority: stall > ret > jump (with or without call) > sequential.
    function automatic pc_cmd_e decode_cmd(
        input logic stall,
        input logic ret,
        input logic jump_valid,
        input logic call
    );
        if (stall)           return CMD_STALL;
        if (ret)             return CMD_RET;
        if (jump_valid)      return call ? CMD_CALL : CMD_JUMP;
        return CMD_SEQ;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack: pushes wrap over the oldest entry when full,
// and the top of stack is always the slot just below the write pointer.
module pc_return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH_DEFAULT,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_idx;

    assign top_idx  = ptr_q - PTR_W'(1);
    assign top      = mem_q[top_idx];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (count_q == FULL_COUNT) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && (count_q != '0)) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read of it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential advance plus jump, call and return
// redirects, with a registered one-cycle pulse for a return on an empty stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     WIDTH        = PC_WIDTH_DEFAULT,
    parameter int unsigned     STEP         = PC_STEP_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       jump_valid,
    input  logic [WIDTH-1:0]           jump_target,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           pc_out,
    output logic [WIDTH-1:0]           pc_plus,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_overflow,
    output logic                       ret_underflow
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam int unsigned      CNT_W  = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             underflow_q, underflow_d;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    pc_cmd_e          cmd;

    assign cmd           = decode_cmd(stall, ret, jump_valid, call);
    assign pc_out        = pc_q;
    assign pc_plus       = pc_q + STEP_W;
    assign ras_empty     = (ras_count == '0);
    assign ras_full      = (ras_count == CNT_W'(RAS_DEPTH));
    assign ret_underflow = underflow_q;

    always_comb begin
        pc_d        = pc_q;
        underflow_d = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        case (cmd)
            CMD_STALL: ;
            CMD_RET: begin
                if (ras_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
            end
            CMD_JUMP: pc_d = jump_target;
            CMD_CALL: begin
                pc_d     = jump_target;
                ras_push = 1'b1;
            end
            default:  pc_d = pc_plus;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q        <= RESET_VECTOR;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    // The return address pushed on a call is the sequential successor of the caller.
    pc_return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ras_push),
        .push_data (pc_plus),
        .pop       (ras_pop),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer: a queue-based return-stack model
// predicts each cycle's outputs, and a separate monitor compares them against the DUT.
module tb_pc_sequencer;

    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [31:0] RV        = 32'h100;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        call;
    logic        ret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ret_underflow;

    pc_sequencer #(
        .WIDTH        (32),
        .STEP         (1),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (RAS_DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ret_underflow (ret_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus;
        logic [31:0] count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: return stack as a plain list, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic rst, st, jv, input logic [31:0] tgt,
                                  input logic c, r);
        if (!rst) begin
            m_pc = RV;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_unf = 1'b0;
            if (st) begin
            end else if (r) begin
                if (m_ras.size() == 0) m_unf = 1'b1;
                else                   m_pc  = m_ras.pop_back();
            end else if (jv) begin
                if (c) begin
                    if (m_ras.size() == RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(m_pc + 32'd1);
                end
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end
    endfunction

    task automatic step(input logic rst, st, jv, input logic [31:0] tgt, input logic c, r);
        exp_t e;
        @(negedge clock);
        reset_n     = rst;
        stall       = st;
        jump_valid  = jv;
        jump_target = tgt;
        call        = c;
        ret         = r;
        model(rst, st, jv, tgt, c, r);
        e.pc      = m_pc;
        e.pc_plus = m_pc + 32'd1;
        e.count   = 32'(m_ras.size());
        e.empty   = (m_ras.size() == 0);
        e.full    = (m_ras.size() == RAS_DEPTH);
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        sb_q.push_back(e);
        @(posedge clock);
    endtask

    task automatic idle();                      step(1, 0, 0, 32'h0, 0, 0); endtask
    task automatic jump(input logic [31:0] t);  step(1, 0, 1, t, 0, 0);     endtask
    task automatic call_to(input logic [31:0] t); step(1, 0, 1, t, 1, 0);   endtask
    task automatic do_ret();                    step(1, 0, 0, 32'h0, 0, 1); endtask

    // Directed spot check against a literal, taken just after the edge that step() waited for.
    task automatic pc_is(input string name, input logic [31:0] exp);
        #2;
        check(name, pc_out, exp);
    endtask

    // Monitor: every cycle the DUT presents a new state, compare it with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_out",        pc_out,               e.pc);
                check("pc_plus",       pc_plus,              e.pc_plus);
                check("ras_count",     32'(ras_count),       e.count);
                check("ras_empty",     32'(ras_empty),       32'(e.empty));
                check("ras_full",      32'(ras_full),        32'(e.full));
                check("ras_overflow",  32'(ras_overflow),    32'(e.ovf));
                check("ret_underflow", 32'(ret_underflow),   32'(e.unf));
            end
        end
    end

    initial begin
        int unsigned r;
        logic [31:0] t;
        reset_n = 1'b0; stall = 1'b0; jump_valid = 1'b0;
        jump_target = '0; call = 1'b0; ret = 1'b0;

        step(0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0);
        pc_is("reset_pc", 32'h100);

        repeat (3) idle();
        pc_is("seq_advance", 32'h103);

        jump(32'h40);
        jump(32'h0);
        pc_is("jump_zero", 32'h0);
        step(1, 1, 1, 32'h55, 0, 0);
        step(1, 1, 1, 32'h55, 1, 1);
        pc_is("stall_hold", 32'h0);

        jump(32'h10);
        call_to(32'h80);
        idle();
        idle();
        pc_is("call_body", 32'h82);
        do_ret();
        pc_is("call_return", 32'h11);

        jump(32'h0);
        call_to(32'h20);
        call_to(32'h40);
        call_to(32'h60);
        call_to(32'h80);
        call_to(32'hA0);
        repeat (4) do_ret();
        pc_is("overflow_last_ret", 32'h21);
        do_ret();
        pc_is("oldest_lost", 32'h21);

        jump(32'h30);
        do_ret();
        pc_is("underflow_hold", 32'h30);
        idle();
        idle();

        jump(32'hFFFF_FFFF);
        idle();
        pc_is("pc_wrap", 32'h0);

        call_to(32'h200);
        step(1, 0, 1, 32'h300, 1, 1);
        pc_is("ret_beats_call", 32'h1);
        step(1, 0, 1, 32'h300, 1, 1);
        call_to(32'h400);
        call_to(32'h500);
        step(0, 0, 1, 32'h600, 1, 0);
        pc_is("reset_mid_call", RV);
        idle();

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       t = 32'h0;
                1:       t = 32'hFFFF_FFFF;
                default: t = $urandom();
            endcase
            if (r < 2)        step(0, 0, 1, t, 1, 0);
            else if (r < 12)  step(1, 1, $urandom_range(0, 1), t, $urandom_range(0, 1), $urandom_range(0, 1));
            else if (r < 32)  step(1, 0, $urandom_range(0, 1), t, $urandom_range(0, 1), 1);
            else if (r < 52)  call_to(t);
            else if (r < 62)  jump(t);
            else if (r < 67)  step(1, 0, 0, t, 1, 0);
            else              idle();
        end

        repeat (3) @(posedge clock);
        #3;
        check("scoreboard_drain", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
